// File: rtl/roc_trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : roc_trig_pkg
//  Description : Shared types and default constants for the ROC trigger path.
//  Revision    : 1.0 - initial release
// ============================================================================
package roc_trig_pkg;

   // Gate edge-capture FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_HOLD = 2'd2
   } gate_state_e;

   localparam int GATE_SYNC_STAGES = 2;
   localparam int GATE_HOLDOFF     = 8;

endpackage : roc_trig_pkg
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : Multi-flop synchroniser for a single asynchronous bit.
//                The chain clears asynchronously so a level present across
//                reset release is always seen as a fresh 0->1 transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[SYNC_STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/gate_edge_capture.sv
`default_nettype none
// ============================================================================
//  Module      : gate_edge_capture
//  Description : Synchronises a stretched gate, emits one pulse per accepted
//                gate, measures gate width, enforces a post-gate holdoff and
//                keeps accepted/dropped event counters plus a stuck flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_edge_capture
   import roc_trig_pkg::*;
#(
   parameter int SYNC_STAGES = GATE_SYNC_STAGES,
   parameter int HOLDOFF     = GATE_HOLDOFF,
   parameter int WIDTH_W     = 8,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 200
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               gate_i,
   input  logic               enable_i,
   input  logic               clear_i,
   output logic               pulse_o,
   output logic [WIDTH_W-1:0] width_o,
   output logic               width_valid_o,
   output logic [CNT_W-1:0]   event_cnt_o,
   output logic [CNT_W-1:0]   drop_cnt_o,
   output logic               stuck_o,
   output logic               busy_o
);

   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam logic [WIDTH_W-1:0] TIMEOUT_VAL = WIDTH_W'(TIMEOUT);
   localparam logic [WIDTH_W-1:0] WIDTH_MAX   = '1;
   localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

   logic               g_s;
   logic               g_d_q;
   logic               rise;
   logic               fall;

   gate_state_e        state_q,       state_d;
   logic [WIDTH_W-1:0] width_cnt_q,   width_cnt_d;
   logic [HOLD_W-1:0]  hold_cnt_q,    hold_cnt_d;
   logic [WIDTH_W-1:0] width_q,       width_d;
   logic               width_valid_q, width_valid_d;
   logic               pulse_q,       pulse_d;
   logic [CNT_W-1:0]   event_cnt_q,   event_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q,    drop_cnt_d;
   logic               stuck_q,       stuck_d;

   sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_gate_sync (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .d_i      (gate_i),
      .q_o      (g_s)
   );

   assign rise = g_s & ~g_d_q;
   assign fall = ~g_s & g_d_q;

   // State and datapath registers
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         g_d_q         <= 1'b0;
         state_q       <= ST_IDLE;
         width_cnt_q   <= '0;
         hold_cnt_q    <= '0;
         width_q       <= '0;
         width_valid_q <= 1'b0;
         pulse_q       <= 1'b0;
         event_cnt_q   <= '0;
         drop_cnt_q    <= '0;
         stuck_q       <= 1'b0;
      end else begin
         g_d_q         <= g_s;
         state_q       <= state_d;
         width_cnt_q   <= width_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         width_q       <= width_d;
         width_valid_q <= width_valid_d;
         pulse_q       <= pulse_d;
         event_cnt_q   <= event_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         stuck_q       <= stuck_d;
      end
   end

   // Next-state: accept a rise in IDLE, leave HIGH on fall, drain the holdoff
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (rise && enable_i) state_d = ST_HIGH;
         ST_HIGH: if (fall) state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
         ST_HOLD: if (hold_cnt_q == '0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath/output next values; clear_i overrides any counter increment
   always_comb begin
      pulse_d       = 1'b0;
      width_valid_d = 1'b0;
      width_cnt_d   = width_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      width_d       = width_q;
      event_cnt_d   = event_cnt_q;
      drop_cnt_d    = drop_cnt_q;
      stuck_d       = stuck_q;
      case (state_q)
         ST_IDLE: begin
            if (rise && enable_i) begin
               pulse_d     = 1'b1;
               event_cnt_d = event_cnt_q + CNT_W'(1);
               width_cnt_d = WIDTH_W'(1);
               if (width_cnt_d == TIMEOUT_VAL) stuck_d = 1'b1;
            end
         end
         ST_HIGH: begin
            if (g_s) begin
               if (width_cnt_q != WIDTH_MAX) width_cnt_d = width_cnt_q + WIDTH_W'(1);
               // Equality (not >=) so a clear while stuck stays cleared
               if (width_cnt_q != WIDTH_MAX && width_cnt_d == TIMEOUT_VAL) stuck_d = 1'b1;
            end else if (fall) begin
               width_d       = width_cnt_q;
               width_valid_d = 1'b1;
               stuck_d       = 1'b0;
               hold_cnt_d    = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (rise && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
         end
         default: ;
      endcase
      if (clear_i) begin
         event_cnt_d = '0;
         drop_cnt_d  = '0;
         stuck_d     = 1'b0;
      end
   end

   assign pulse_o       = pulse_q;
   assign width_o       = width_q;
   assign width_valid_o = width_valid_q;
   assign event_cnt_o   = event_cnt_q;
   assign drop_cnt_o    = drop_cnt_q;
   assign stuck_o       = stuck_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule : gate_edge_capture
`default_nettype wire

// File: tb/tb_gate_edge_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_edge_capture
//  Description : Directed self-checking bench for gate_edge_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_edge_capture;

   logic        clk_i = 1'b0;
   logic        resetn_i;
   logic        gate_i;
   logic        enable_i;
   logic        clear_i;
   logic        pulse_o;
   logic [7:0]  width_o;
   logic        width_valid_o;
   logic [15:0] event_cnt_o;
   logic [15:0] drop_cnt_o;
   logic        stuck_o;
   logic        busy_o;

   int vectors     = 0;
   int miscompares = 0;

   // Running totals kept by the monitor; tasks take deltas
   int   n_pulse = 0;
   int   n_wv    = 0;
   logic prev_pulse = 1'b0;
   logic prev_wv    = 1'b0;
   logic dbl        = 1'b0;

   gate_edge_capture #(
      .SYNC_STAGES (2),
      .HOLDOFF     (8),
      .WIDTH_W     (8),
      .CNT_W       (16),
      .TIMEOUT     (200)
   ) dut (
      .clk_i         (clk_i),
      .resetn_i      (resetn_i),
      .gate_i        (gate_i),
      .enable_i      (enable_i),
      .clear_i       (clear_i),
      .pulse_o       (pulse_o),
      .width_o       (width_o),
      .width_valid_o (width_valid_o),
      .event_cnt_o   (event_cnt_o),
      .drop_cnt_o    (drop_cnt_o),
      .stuck_o       (stuck_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Count strobes and flag any strobe lasting two consecutive cycles
   always @(negedge clk_i) begin
      prev_pulse <= pulse_o;
      prev_wv    <= width_valid_o;
      if (pulse_o && prev_pulse)       dbl <= 1'b1;
      if (width_valid_o && prev_wv)    dbl <= 1'b1;
      if (pulse_o)       n_pulse <= n_pulse + 1;
      if (width_valid_o) n_wv    <= n_wv + 1;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive(input int hi, input int lo);
      gate_i = 1'b1;
      steps(hi);
      gate_i = 1'b0;
      steps(lo);
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      gate_i   = 1'b0;
      enable_i = 1'b1;
      clear_i  = 1'b0;
      steps(3);
      vectors++;
      if ({pulse_o, width_valid_o, stuck_o, busy_o} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0000", {pulse_o, width_valid_o, stuck_o, busy_o});
      end
      vectors++;
      if ({width_o, event_cnt_o, drop_cnt_o} !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_values: got w=%0d ev=%0d dr=%0d want 0/0/0", width_o, event_cnt_o, drop_cnt_o);
      end
      resetn_i = 1'b1;
      steps(2);
   endtask

   task automatic test_single();
      gate_i = 1'b1;
      steps(2);                         // edges k, k+1
      vectors++;
      if (pulse_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_early: got %b want 0", pulse_o);
      end
      step();                           // edge k+2
      vectors++;
      if (pulse_o !== 1'b1) begin
         miscompares++;
         $display("FAIL single_latency: got %b want 1", pulse_o);
      end
      step();                           // edge k+3, last high sample
      gate_i = 1'b0;
      vectors++;
      if (pulse_o !== 1'b0 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL single_pulse_len: got pulse=%b busy=%b want 0/1", pulse_o, busy_o);
      end
      steps(2);                         // edges k+4, k+5
      vectors++;
      if (width_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_wv_early: got %b want 0", width_valid_o);
      end
      step();                           // edge k+6: fall seen
      vectors++;
      if (width_valid_o !== 1'b1 || width_o !== 8'd4) begin
         miscompares++;
         $display("FAIL single_width: got wv=%b w=%0d want 1/4", width_valid_o, width_o);
      end
      step();
      vectors++;
      if (width_valid_o !== 1'b0 || event_cnt_o !== 16'd1) begin
         miscompares++;
         $display("FAIL single_after: got wv=%b ev=%0d want 0/1", width_valid_o, event_cnt_o);
      end
      steps(15);
   endtask

   task automatic test_holdoff_reject();
      int p0, w0;
      do_clear();
      p0 = n_pulse;
      w0 = n_wv;
      drive(4, 2);
      drive(3, 20);
      vectors++;
      if (n_pulse - p0 !== 1 || n_wv - w0 !== 1) begin
         miscompares++;
         $display("FAIL holdoff_reject_strobes: got pulses=%0d wv=%0d want 1/1", n_pulse - p0, n_wv - w0);
      end
      vectors++;
      if (event_cnt_o !== 16'd1 || drop_cnt_o !== 16'd1) begin
         miscompares++;
         $display("FAIL holdoff_reject_counts: got ev=%0d dr=%0d want 1/1", event_cnt_o, drop_cnt_o);
      end
   endtask

   task automatic test_holdoff_clear();
      int p0, w0;
      do_clear();
      p0 = n_pulse;
      w0 = n_wv;
      drive(4, 12);
      drive(3, 20);
      vectors++;
      if (n_pulse - p0 !== 2 || n_wv - w0 !== 2) begin
         miscompares++;
         $display("FAIL holdoff_clear_strobes: got pulses=%0d wv=%0d want 2/2", n_pulse - p0, n_wv - w0);
      end
      vectors++;
      if (event_cnt_o !== 16'd2 || drop_cnt_o !== 16'd0 || width_o !== 8'd3) begin
         miscompares++;
         $display("FAIL holdoff_clear_counts: got ev=%0d dr=%0d w=%0d want 2/0/3", event_cnt_o, drop_cnt_o, width_o);
      end
   endtask

   task automatic test_stuck();
      int  first;
      bit  seen;
      do_clear();
      first  = -1;
      gate_i = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (stuck_o === 1'b1 && first < 0) first = i;
      end
      vectors++;
      if (first !== 202 || stuck_o !== 1'b1) begin
         miscompares++;
         $display("FAIL stuck_rise: got first_step=%0d stuck=%b want 202/1", first, stuck_o);
      end
      gate_i = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (width_valid_o === 1'b1) begin
            seen = 1'b1;
            vectors++;
            if (width_o !== 8'd255 || stuck_o !== 1'b0) begin
               miscompares++;
               $display("FAIL stuck_fall: got w=%0d stuck=%b want 255/0", width_o, stuck_o);
            end
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL stuck_fall_timeout: got no width_valid want one within 10 cycles");
      end
      steps(15);
   endtask

   task automatic test_enable_clear();
      int p0;
      do_clear();
      enable_i = 1'b0;
      p0 = n_pulse;
      drive(4, 15);
      vectors++;
      if (n_pulse - p0 !== 0 || event_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL disabled: got pulses=%0d ev=%0d dr=%0d busy=%b want 0/0/0/0",
                  n_pulse - p0, event_cnt_o, drop_cnt_o, busy_o);
      end
      enable_i = 1'b1;
      for (int j = 0; j < 3; j++) begin
         drive(2, 2);
         drive(2, 20);
      end
      for (int j = 0; j < 2; j++) drive(2, 15);
      vectors++;
      if (event_cnt_o !== 16'd5 || drop_cnt_o !== 16'd3) begin
         miscompares++;
         $display("FAIL preclear_counts: got ev=%0d dr=%0d want 5/3", event_cnt_o, drop_cnt_o);
      end
      do_clear();
      vectors++;
      if (event_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin
         miscompares++;
         $display("FAIL clear_counts: got ev=%0d dr=%0d want 0/0", event_cnt_o, drop_cnt_o);
      end
      // Clear coincident with an accept: pulse still issued, count reads 0
      gate_i = 1'b1;
      steps(2);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      vectors++;
      if (pulse_o !== 1'b1 || event_cnt_o !== 16'd0) begin
         miscompares++;
         $display("FAIL clear_coincident: got pulse=%b ev=%0d want 1/0", pulse_o, event_cnt_o);
      end
      steps(3);
      gate_i = 1'b0;
      steps(20);
   endtask

   task automatic test_reset_mid();
      do_clear();
      gate_i = 1'b1;
      steps(6);
      vectors++;
      if (busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midgate_busy: got %b want 1", busy_o);
      end
      #2 resetn_i = 1'b0;
      #1;
      vectors++;
      if ({pulse_o, width_valid_o, stuck_o, busy_o, width_o, event_cnt_o, drop_cnt_o} !== 44'd0) begin
         miscompares++;
         $display("FAIL midgate_reset: got p=%b wv=%b st=%b b=%b w=%0d ev=%0d dr=%0d want all 0",
                  pulse_o, width_valid_o, stuck_o, busy_o, width_o, event_cnt_o, drop_cnt_o);
      end
      steps(2);
      resetn_i = 1'b1;
      steps(2);
      vectors++;
      if (pulse_o !== 1'b0) begin
         miscompares++;
         $display("FAIL release_early: got %b want 0", pulse_o);
      end
      step();
      vectors++;
      if (pulse_o !== 1'b1 || event_cnt_o !== 16'd1) begin
         miscompares++;
         $display("FAIL release_pulse: got pulse=%b ev=%0d want 1/1", pulse_o, event_cnt_o);
      end
      gate_i = 1'b0;
      steps(20);
   endtask

   task automatic test_strobe_width();
      vectors++;
      if (dbl !== 1'b0) begin
         miscompares++;
         $display("FAIL strobe_single_cycle: got double=%b want 0", dbl);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_holdoff_reject();
      test_holdoff_clear();
      test_stuck();
      test_enable_clear();
      test_reset_mid();
      test_strobe_width();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_gate_edge_capture
`default_nettype wire
